// File: rtl/mmio_uart_responder.sv
// MMIO-mapped UART: control/RX/TX registers behind a single-cycle request port,
// with an 8N1 transmitter and a 2-flop-synchronized receiver.

package mmio_uart_pkg;
   localparam int ARCH_WIDTH = 32;

   typedef enum int unsigned {
      BR_9600   = 9600,
      BR_19200  = 19200,
      BR_38400  = 38400,
      BR_57600  = 57600,
      BR_115200 = 115200
   } uart_baud_rate_t;

   typedef enum logic {
      DMEM_READ  = 1'b0,
      DMEM_WRITE = 1'b1
   } dmem_rtype_t;

   typedef enum logic [1:0] {
      DMEM_BYTE = 2'd0,
      DMEM_HALF = 2'd1,
      DMEM_WORD = 2'd2
   } dmem_dtype_t;

   typedef enum logic [1:0] {
      UART_CTRL = 2'd0,
      UART_RX   = 2'd1,
      UART_TX   = 2'd2
   } uart_addr_t;
endpackage

module mmio_uart_responder
   import mmio_uart_pkg::*;
#(
   parameter int unsigned     CLK_FREQ  = 100_000_000,
   parameter uart_baud_rate_t BAUD_RATE = BR_115200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  dmem_rtype_t           req_rtype,
   input  dmem_dtype_t           req_dtype,
   input  logic [ARCH_WIDTH-1:0] req_addr,
   input  logic [ARCH_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_data,
   input  logic                  serial_in,
   output logic                  serial_out
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / 32'(BAUD_RATE);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("mmio_uart_responder: CLKS_PER_BIT must be at least 4");
   end

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   uart_addr_t       addr_sel;
   logic             rd_acc;
   logic             wr_acc;
   logic             rd_rx;
   logic             tx_go;
   logic             tx_ready;
   logic [31:0]      rd_data;

   logic [1:0]       tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;
   logic [7:0]       tx_byte;

   logic [1:0]       sync_q;
   logic             rx_s;
   logic [1:0]       rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             rx_done;
   logic [7:0]       rx_data;
   logic             rx_valid;

   logic             unused_bits;

   // Always ready outside reset, so the first edge after release already accepts.
   assign req_ready = ~rst;

   assign addr_sel = uart_addr_t'(req_addr[3:2]);
   assign rd_acc   = req_valid && (req_rtype == DMEM_READ);
   assign wr_acc   = req_valid && (req_rtype == DMEM_WRITE);
   assign rd_rx    = rd_acc && (addr_sel == UART_RX);
   assign tx_ready = (tx_state == TX_IDLE);
   assign tx_go    = wr_acc && (addr_sel == UART_TX) && tx_ready;

   assign unused_bits = ^{req_addr[ARCH_WIDTH-1:4], req_addr[1:0],
                          req_wdata[ARCH_WIDTH-1:8], req_dtype};

   always_comb begin
      rd_data = 32'h0;
      case (addr_sel)
         UART_CTRL: rd_data = {30'b0, rx_valid, tx_ready};
         UART_RX:   rd_data = {24'b0, rx_data};
         UART_TX:   rd_data = {24'b0, tx_byte};
         default:   rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0;
      end else begin
         rsp_valid <= rd_acc;
         if (rd_acc) rsp_data <= rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_shift   <= '0;
         tx_byte    <= '0;
         serial_out <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_go) begin
                  tx_state   <= TX_START;
                  tx_byte    <= req_wdata[7:0];
                  tx_shift   <= req_wdata[7:0];
                  tx_cnt     <= '0;
                  serial_out <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_state   <= TX_DATA;
                  tx_cnt     <= '0;
                  tx_bit     <= '0;
                  serial_out <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_state   <= TX_STOP;
                     serial_out <= 1'b1;
                  end else begin
                     tx_bit     <= tx_bit + 1'b1;
                     serial_out <= tx_shift[1];
                     tx_shift   <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_state <= TX_IDLE;
                  tx_cnt   <= '0;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Synchronizer resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], serial_in};
   end

   assign rx_s    = sync_q[1];
   assign rx_done = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // A completing byte wins over a same-edge RX read; the read still sees the old byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else if (rx_done) begin
         rx_data  <= rx_shift;
         rx_valid <= 1'b1;
      end else if (rd_rx) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed-plus-random bench for mmio_uart_responder: register reads, TX framing,
// RX reception, error cases and mid-frame reset, checked against a byte-level model.

module tb_mmio_uart_responder;
   import mmio_uart_pkg::*;

   localparam int unsigned CLK_FREQ = 1_152_000;
   localparam int          BIT_CYC  = 1_152_000 / 115_200;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   dmem_rtype_t req_rtype;
   dmem_dtype_t req_dtype;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        serial_in;
   logic        serial_out;

   int checks = 0;
   int errors = 0;

   mmio_uart_responder #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BR_115200)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rtype  (req_rtype),
      .req_dtype  (req_dtype),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .serial_in  (serial_in),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Random bits outside [3:2] must not change the decoded register.
   function automatic logic [31:0] addr_of(input logic [1:0] idx);
      logic [27:0] hi;
      logic [1:0]  lo;
      hi = 28'($urandom());
      lo = 2'($urandom_range(0, 3));
      return {hi, idx, lo};
   endfunction

   task automatic mmio_read(input logic [1:0] idx, input logic [31:0] exp, input string tag);
      req_valid = 1'b1;
      req_rtype = DMEM_READ;
      req_dtype = DMEM_WORD;
      req_addr  = addr_of(idx);
      req_wdata = $urandom();
      tick;
      req_valid = 1'b0;
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check(tag, rsp_data, exp);
      tick;
      check({tag, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic mmio_write(input logic [1:0] idx, input logic [31:0] data);
      req_valid = 1'b1;
      req_rtype = DMEM_WRITE;
      req_dtype = dmem_dtype_t'($urandom_range(0, 2));
      req_addr  = addr_of(idx);
      req_wdata = data;
      tick;
      req_valid = 1'b0;
      check("write no rsp", 32'(rsp_valid), 32'd0);
   endtask

   // Called right after the accepting edge; polls CTRL every cycle for tx_ready and
   // optionally slips in a write of 8'h3C at iteration drop_at.
   task automatic watch_tx(input logic [7:0] b, input int drop_at, input string tag);
      logic [9:0] frame;
      logic       exp_bit;
      frame = {1'b1, b, 1'b0};
      check({tag, " start"}, 32'(serial_out), 32'd0);
      req_valid = 1'b1;
      req_dtype = DMEM_WORD;
      for (int i = 1; i <= 110; i++) begin
         if (i == drop_at) begin
            req_rtype = DMEM_WRITE;
            req_addr  = addr_of(UART_TX);
            req_wdata = {24'($urandom()), 8'h3C};
         end else begin
            req_rtype = DMEM_READ;
            req_addr  = addr_of(UART_CTRL);
         end
         tick;
         exp_bit = (i < 10 * BIT_CYC) ? frame[i / BIT_CYC] : 1'b1;
         check($sformatf("%s bit@%0d", tag, i), 32'(serial_out), 32'(exp_bit));
         if (i == drop_at)
            check({tag, " dropped write rsp"}, 32'(rsp_valid), 32'd0);
         else
            check($sformatf("%s tx_ready@%0d", tag, i), 32'({rsp_valid, rsp_data[0]}),
                  32'({1'b1, (i - 1) >= 10 * BIT_CYC}));
      end
      req_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         serial_in = frame[k];
         repeat (BIT_CYC) tick;
      end
      serial_in = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] r;
      logic [7:0] last_rx;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_rtype = DMEM_READ;
      req_dtype = DMEM_WORD;
      req_addr  = '0;
      req_wdata = '0;
      serial_in = 1'b1;
      #2;
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data", rsp_data, 32'h0);
      check("reset serial_out", 32'(serial_out), 32'd1);
      repeat (3) tick;
      rst = 1'b0;
      check("req_ready", 32'(req_ready), 32'd1);

      // Register map after reset
      mmio_read(UART_CTRL, 32'h1, "ctrl after reset");
      mmio_read(UART_RX, 32'h0, "rx after reset");
      mmio_read(UART_TX, 32'h0, "tx after reset");
      mmio_read(2'd3, 32'h0, "index3");

      // Writes to non-TX registers have no effect
      mmio_write(UART_CTRL, $urandom());
      mmio_write(UART_RX, $urandom());
      mmio_write(2'd3, $urandom());
      mmio_read(UART_CTRL, 32'h1, "ctrl after ignored writes");
      mmio_read(UART_TX, 32'h0, "tx after ignored writes");

      // A5 frame with a dropped 3C write mid-frame
      mmio_write(UART_TX, {24'($urandom()), 8'hA5});
      watch_tx(8'hA5, 30, "txA5");
      mmio_read(UART_TX, 32'hA5, "tx byte after drop");

      // Random TX and RX running at the same time
      b = 8'($urandom());
      r = 8'($urandom());
      fork
         begin
            mmio_write(UART_TX, {24'($urandom()), b});
            watch_tx(b, -1, "tx concurrent");
         end
         send_rx(r, 1'b1);
      join
      repeat (20) tick;
      mmio_read(UART_CTRL, 32'h3, "ctrl rx+tx ready");
      mmio_read(UART_TX, {24'b0, b}, "tx byte concurrent");
      mmio_read(UART_RX, {24'b0, r}, "rx byte concurrent");
      mmio_read(UART_CTRL, 32'h1, "ctrl after rx read");

      // 5A received while a later-started TX frame is still busy
      fork
         begin
            repeat (20) tick;
            mmio_write(UART_TX, $urandom());
         end
         send_rx(8'h5A, 1'b1);
      join
      mmio_read(UART_CTRL, 32'h2, "ctrl rx valid tx busy");
      mmio_read(UART_RX, 32'h5A, "rx 5A");
      repeat (40) tick;
      mmio_read(UART_CTRL, 32'h1, "ctrl after 5A");

      // Overrun: second byte overwrites, valid stays set
      r = 8'($urandom());
      send_rx(r, 1'b1);
      repeat (20) tick;
      last_rx = 8'($urandom());
      send_rx(last_rx, 1'b1);
      repeat (20) tick;
      mmio_read(UART_CTRL, 32'h3, "ctrl overrun");
      mmio_read(UART_RX, {24'b0, last_rx}, "rx overrun byte");
      mmio_read(UART_CTRL, 32'h1, "ctrl after overrun read");

      // Short low glitch is a false start
      serial_in = 1'b0;
      repeat (3) tick;
      serial_in = 1'b1;
      repeat (30) tick;
      mmio_read(UART_CTRL, 32'h1, "ctrl after glitch");

      // Framing error discards the byte
      send_rx(~last_rx, 1'b0);
      repeat (30) tick;
      mmio_read(UART_CTRL, 32'h1, "ctrl after framing error");
      mmio_read(UART_RX, {24'b0, last_rx}, "rx after framing error");

      // Reset at cycle 40 of a TX frame; data bit 3 is on the line then
      b = 8'($urandom()) & 8'hF7;
      mmio_write(UART_TX, {24'b0, b});
      repeat (4 * BIT_CYC) tick;
      check("mid-frame low bit", 32'(serial_out), 32'd0);
      rst = 1'b1;
      #1;
      check("async rst serial_out", 32'(serial_out), 32'd1);
      check("async rst tx_ready", 32'(dut.tx_ready), 32'd1);
      check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) tick;
      rst = 1'b0;
      mmio_read(UART_CTRL, 32'h1, "ctrl after mid reset");
      mmio_read(UART_TX, 32'h0, "tx byte after mid reset");
      mmio_read(UART_RX, 32'h0, "rx byte after mid reset");
      b = 8'($urandom());
      mmio_write(UART_TX, {24'($urandom()), b});
      watch_tx(b, -1, "tx after reset");
      mmio_read(UART_TX, {24'b0, b}, "tx byte after reset frame");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
